bit_serializer: RTL



---
 rtl/bit_serializer_pkg.sv | 15 +
 rtl/bit_serializer_if.sv | 22 ++
 rtl/bit_serializer.sv | 97 +++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared constants and state encoding for the serial front end
package serial_pkg;

  localparam int   DEF_WIDTH    = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Pattern recognised by the downstream detector, oldest bit in [3]
  localparam logic [3:0] SEQ_1010 = 4'b1010;

endpackage

// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word input handshake and serial output bundle
interface bit_serializer_if #(
  parameter int WIDTH = serial_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - double-buffered parallel-to-serial converter feeding the 1010 detector
module bit_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic            clk,
  input  logic            reset,
  bit_serializer_if.slave s
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  ser_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [WIDTH-1:0] r_buf, w_buf_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_buf_full, w_buf_full_nxt;

  logic             w_active;
  logic             w_last;
  logic             w_done;
  logic             w_accept;
  logic             w_cur_bit;
  logic [WIDTH-1:0] w_shifted;

  assign w_active = (r_state == ST_SHIFT);
  assign w_last   = w_active && (r_cnt == LAST_CNT);
  assign w_done   = !w_active || w_last;
  assign w_accept = s.din_valid && !r_buf_full;

  // The emitted bit always sits at the end the register shifts toward
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_cur_bit = r_shreg[WIDTH-1];
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign w_cur_bit = r_shreg[0];
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign s.din_ready  = !r_buf_full;
  assign s.sout_valid = w_active;
  assign s.sout       = w_active ? w_cur_bit : IDLE_BIT;
  assign s.sout_last  = w_last;
  assign s.busy       = w_active || r_buf_full;

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_cnt_nxt      = r_cnt;
    w_buf_nxt      = r_buf;
    w_buf_full_nxt = r_buf_full;
    if (w_done) begin
      w_cnt_nxt = '0;
      if (r_buf_full) begin
        w_shreg_nxt    = r_buf;
        w_buf_full_nxt = 1'b0;
        w_state_nxt    = ST_SHIFT;
      end else if (w_accept) begin
        // Bypass: a word arriving on the last bit streams without a gap
        w_shreg_nxt = s.din;
        w_state_nxt = ST_SHIFT;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      w_shreg_nxt = w_shifted;
      w_cnt_nxt   = r_cnt + CW'(1);
      if (w_accept) begin
        w_buf_nxt      = s.din;
        w_buf_full_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_cnt      <= w_cnt_nxt;
      r_buf      <= w_buf_nxt;
      r_buf_full <= w_buf_full_nxt;
    end
  end

endmodule
